// File: rtl/i2c_slave_regs.sv
// I2C slave front end for a register file.
// A 7-bit device address is followed by a register pointer byte; subsequent
// written bytes are strobed out with auto-increment. A repeated START with
// R/W=1 reads bytes starting at the current pointer.
// Ports:
//   clk, rstn_in    system clock, asynchronous active-low reset
//   scl, sda        raw pad inputs
//   sda_out         open-drain drive (0 = pull low, 1 = release)
//   act_out         transaction addressed to this device is in progress
//   ptr_out         current register pointer (PW bits)
//   dat_in          read data for ptr_out, sampled 1 clk after rs_out
//   rs_out          read strobe
//   dat_out, ws_out write data / write strobe (address = ptr_out)
//   as_out, ps_out  address-match strobe, STOP strobe
module i2c_slave_regs #(
  parameter logic [6:0] MYADDR = 7'h3b,
  parameter int         PW     = 8,
  parameter int         FILT   = 3,
  parameter int         HOLD   = 2
) (
  input  logic          clk,
  input  logic          rstn_in,
  input  logic          scl,
  input  logic          sda,
  output logic          sda_out,
  output logic          act_out,
  output logic [PW-1:0] ptr_out,
  input  logic [7:0]    dat_in,
  output logic          rs_out,
  output logic [7:0]    dat_out,
  output logic          ws_out,
  output logic          as_out,
  output logic          ps_out
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDAT, WDAT_ACK, RDAT, RDAT_MACK
  } state_t;

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0] sync1, sync2, filt, filt_d;
  logic [2:0] fcnt [2];

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      sync1   <= '1;
      sync2   <= '1;
      filt    <= '1;
      filt_d  <= '1;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= {sda, scl};
      sync2  <= sync1;
      filt_d <= filt;
      // Filtered level follows only after FILT consecutive differing samples.
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == 3'(FILT - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 3'd1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, start, stop;
  assign scl_rise = filt[0] & ~filt_d[0];
  assign scl_fall = ~filt[0] & filt_d[0];
  assign start    = filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
  assign stop     = filt[0] & filt_d[0] & ~filt_d[1] & filt[1];

  state_t     state;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       rw;
  logic [7:0] rx;
  assign rx = {shreg[6:0], filt[1]};

  // SDA level to present for the low phase that begins at this SCL fall.
  // ACK states see two falls: the first starts the ACK (bitcnt==0),
  // the second ends it and hands over to the next phase.
  logic fall_drv, fall_val;
  always_comb begin
    fall_drv = 1'b0;
    fall_val = 1'b1;
    if (scl_fall && !start && !stop) begin
      case (state)
        ADDR_ACK, PTR_ACK, WDAT_ACK: begin
          fall_drv = 1'b1;
          if (bitcnt == 3'd0)
            fall_val = 1'b0;
          else if (state == ADDR_ACK && rw)
            fall_val = shreg[7];
        end
        RDAT: begin
          fall_drv = 1'b1;
          fall_val = shreg[7];
        end
        RDAT_MACK: fall_drv = 1'b1;
        default: ;
      endcase
    end
  end

  // Output hold: the fall is detected one clk after the filtered level
  // changed, so the remaining HOLD-1 clks are counted from detection.
  logic       pend;
  logic [3:0] hcnt;
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      sda_out <= 1'b1;
      pend    <= 1'b1;
      hcnt    <= '0;
    end else if (start || stop || state == IDLE) begin
      sda_out <= 1'b1;
      hcnt    <= '0;
    end else if (fall_drv) begin
      if (HOLD == 1) begin
        sda_out <= fall_val;
      end else begin
        pend <= fall_val;
        hcnt <= 4'(HOLD - 1);
      end
    end else if (hcnt != 4'd0) begin
      hcnt <= hcnt - 4'd1;
      if (hcnt == 4'd1) sda_out <= pend;
    end
  end

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      state   <= IDLE;
      bitcnt  <= '0;
      shreg   <= '0;
      rw      <= 1'b0;
      ptr_out <= '0;
      act_out <= 1'b0;
      dat_out <= '0;
      rs_out  <= 1'b0;
      ws_out  <= 1'b0;
      as_out  <= 1'b0;
      ps_out  <= 1'b0;
    end else begin
      rs_out <= 1'b0;
      ws_out <= 1'b0;
      as_out <= 1'b0;
      ps_out <= 1'b0;
      if (rs_out) shreg <= dat_in;
      if (stop) begin
        state   <= IDLE;
        act_out <= 1'b0;
        ps_out  <= 1'b1;
        bitcnt  <= '0;
      end else if (start) begin
        state  <= ADDR;
        bitcnt <= '0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg  <= rx;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (rx[7:1] == MYADDR) begin
                state   <= ADDR_ACK;
                as_out  <= 1'b1;
                act_out <= 1'b1;
                rw      <= rx[0];
                rs_out  <= rx[0];
              end else begin
                state   <= IDLE;
                act_out <= 1'b0;
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDAT_ACK: if (scl_fall) begin
            if (bitcnt == 3'd0) begin
              bitcnt <= 3'd1;
            end else begin
              bitcnt <= '0;
              if (state == ADDR_ACK) begin
                state <= rw ? RDAT : PTR;
              end else if (state == PTR_ACK) begin
                state <= WDAT;
              end else begin
                ptr_out <= ptr_out + 1'b1;
                state   <= WDAT;
              end
            end
          end
          PTR, WDAT: if (scl_rise) begin
            shreg  <= rx;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (state == PTR) begin
                ptr_out <= rx[PW-1:0];
                state   <= PTR_ACK;
              end else begin
                dat_out <= rx;
                ws_out  <= 1'b1;
                state   <= WDAT_ACK;
              end
            end
          end
          // Shift on the rise so every fall in RDAT presents shreg[7].
          RDAT: if (scl_rise) begin
            shreg  <= {shreg[6:0], 1'b0};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= RDAT_MACK;
          end
          RDAT_MACK: if (scl_rise) begin
            if (!filt[1]) begin
              ptr_out <= ptr_out + 1'b1;
              rs_out  <= 1'b1;
              state   <= RDAT;
            end else begin
              act_out <= 1'b0;
              state   <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: an open-drain I2C master model drives
// two instances (PW=8 and PW=4) on separate buses selected by sel.
module tb_i2c_slave_regs;

  localparam int Q = 20;  // SCL quarter-ish phase in clks

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic scl_m = 1'b1, sda_m = 1'b1, sel = 1'b0;

  logic scl0, sda0, sda_out0, act0, rs0, ws0, as0, ps0;
  logic [7:0] ptr0, din0, dout0;
  logic scl4, sda4, sda_out4, act4, rs4, ws4, as4, ps4;
  logic [3:0] ptr4;
  logic [7:0] din4, dout4;
  logic sda_bus;

  assign scl0 = sel ? 1'b1 : scl_m;
  assign sda0 = (sel ? 1'b1 : sda_m) & sda_out0;
  assign scl4 = sel ? scl_m : 1'b1;
  assign sda4 = (sel ? sda_m : 1'b1) & sda_out4;
  assign sda_bus = sel ? sda4 : sda0;
  assign din0 = ptr0 + 8'h40;
  assign din4 = {4'h0, ptr4} + 8'h40;

  always #5 clk = ~clk;

  i2c_slave_regs dut (
    .clk(clk), .rstn_in(rstn), .scl(scl0), .sda(sda0), .sda_out(sda_out0),
    .act_out(act0), .ptr_out(ptr0), .dat_in(din0), .rs_out(rs0),
    .dat_out(dout0), .ws_out(ws0), .as_out(as0), .ps_out(ps0)
  );

  i2c_slave_regs #(.PW(4)) dut4 (
    .clk(clk), .rstn_in(rstn), .scl(scl4), .sda(sda4), .sda_out(sda_out4),
    .act_out(act4), .ptr_out(ptr4), .dat_in(din4), .rs_out(rs4),
    .dat_out(dout4), .ws_out(ws4), .as_out(as4), .ps_out(ps4)
  );

  int n_cmp = 0, n_fail = 0;
  int as_cnt = 0, rs_cnt = 0, ws_cnt = 0, ps_cnt = 0, width_err = 0;
  logic [7:0] ws_ptr[$], ws_dat[$], ws4_ptr[$], ws4_dat[$];
  logic [7:0] strb_q = '0;

  always @(posedge clk) begin
    if (as0) as_cnt <= as_cnt + 1;
    if (rs0) rs_cnt <= rs_cnt + 1;
    if (ps0) ps_cnt <= ps_cnt + 1;
    if (ws0) begin
      ws_cnt <= ws_cnt + 1;
      ws_ptr.push_back(ptr0);
      ws_dat.push_back(dout0);
    end
    if (ws4) begin
      ws4_ptr.push_back({4'h0, ptr4});
      ws4_dat.push_back(dout4);
    end
    strb_q <= {as0, rs0, ws0, ps0, as4, rs4, ws4, ps4};
    if (|({as0, rs0, ws0, ps0, as4, rs4, ws4, ps4} & strb_q))
      width_err <= width_err + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic bit_w(input logic b);
    sda_m = b;    wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic bit_r(output logic b);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q / 2);
    b = sda_bus;  wait_clks(Q / 2);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic byte_w(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(b[i]);
    bit_r(ack);
  endtask

  task automatic byte_r(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      d[i] = b;
    end
    bit_w(mack);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    wait_clks(4);
    n_cmp++; if (sda_out0 !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b required 1", sda_out0); end
    n_cmp++; if (act0 !== 1'b0) begin n_fail++; $display("FAIL reset_act: got %b required 0", act0); end
    n_cmp++; if (ptr0 !== 8'h00) begin n_fail++; $display("FAIL reset_ptr: got %h required 00", ptr0); end
    n_cmp++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL reset_dat: got %h required 00", dout0); end
    n_cmp++; if ({as0, rs0, ws0, ps0} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b required 0000", {as0, rs0, ws0, ps0}); end
    rstn = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    int w0, p0, s0, r0;
    w0 = ws_cnt; p0 = ps_cnt; s0 = as_cnt; r0 = rs_cnt;
    i2c_start();
    byte_w(8'h76, a0);
    n_cmp++; if (act0 !== 1'b1) begin n_fail++; $display("FAIL wr_act: got %b required 1", act0); end
    byte_w(8'h10, a1);
    byte_w(8'hA5, a2);
    byte_w(8'h5A, a3);
    i2c_stop();
    wait_clks(4);
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_fail++; $display("FAIL wr_acks: got %b required 0000", {a0, a1, a2, a3}); end
    n_cmp++; if (ws_cnt - w0 !== 2) begin n_fail++; $display("FAIL wr_ws_count: got %0d required 2", ws_cnt - w0); end
    if (ws_cnt - w0 == 2) begin
      n_cmp++; if ({ws_ptr[w0], ws_dat[w0]} !== 16'h10A5) begin n_fail++; $display("FAIL wr_first: got %h/%h required 10/A5", ws_ptr[w0], ws_dat[w0]); end
      n_cmp++; if ({ws_ptr[w0+1], ws_dat[w0+1]} !== 16'h115A) begin n_fail++; $display("FAIL wr_second: got %h/%h required 11/5A", ws_ptr[w0+1], ws_dat[w0+1]); end
    end
    n_cmp++; if (ps_cnt - p0 !== 1) begin n_fail++; $display("FAIL wr_ps: got %0d required 1", ps_cnt - p0); end
    n_cmp++; if (as_cnt - s0 !== 1) begin n_fail++; $display("FAIL wr_as: got %0d required 1", as_cnt - s0); end
    n_cmp++; if (rs_cnt - r0 !== 0) begin n_fail++; $display("FAIL wr_rs: got %0d required 0", rs_cnt - r0); end
    n_cmp++; if (act0 !== 1'b0) begin n_fail++; $display("FAIL wr_act_stop: got %b required 0", act0); end
    n_cmp++; if (ptr0 !== 8'h12) begin n_fail++; $display("FAIL wr_ptr_end: got %h required 12", ptr0); end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    int r0, w0;
    r0 = rs_cnt; w0 = ws_cnt;
    i2c_start();
    byte_w(8'h76, a0);
    byte_w(8'h20, a1);
    i2c_start();
    byte_w(8'h77, a2);
    byte_r(d0, 1'b0);
    byte_r(d1, 1'b1);
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL rd_acks: got %b required 000", {a0, a1, a2}); end
    n_cmp++; if (d0 !== 8'h60) begin n_fail++; $display("FAIL rd_byte0: got %h required 60", d0); end
    n_cmp++; if (d1 !== 8'h61) begin n_fail++; $display("FAIL rd_byte1: got %h required 61", d1); end
    n_cmp++; if (act0 !== 1'b0) begin n_fail++; $display("FAIL rd_act_nack: got %b required 0", act0); end
    n_cmp++; if (sda_out0 !== 1'b1) begin n_fail++; $display("FAIL rd_sda_nack: got %b required 1", sda_out0); end
    n_cmp++; if (rs_cnt - r0 !== 2) begin n_fail++; $display("FAIL rd_rs_count: got %0d required 2", rs_cnt - r0); end
    n_cmp++; if (ws_cnt - w0 !== 0) begin n_fail++; $display("FAIL rd_ws_count: got %0d required 0", ws_cnt - w0); end
    i2c_stop();
  endtask

  task automatic test_nomatch();
    logic a0;
    int s0, r0, w0;
    s0 = as_cnt; r0 = rs_cnt; w0 = ws_cnt;
    i2c_start();
    byte_w(8'h78, a0);
    n_cmp++; if (a0 !== 1'b1) begin n_fail++; $display("FAIL nm_ack: got %b required 1", a0); end
    n_cmp++; if (act0 !== 1'b0) begin n_fail++; $display("FAIL nm_act: got %b required 0", act0); end
    n_cmp++; if ((as_cnt - s0) + (rs_cnt - r0) + (ws_cnt - w0) !== 0) begin n_fail++; $display("FAIL nm_strobes: got %0d required 0", (as_cnt - s0) + (rs_cnt - r0) + (ws_cnt - w0)); end
    i2c_stop();
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    int k;
    k = ws4_ptr.size();
    sel = 1'b1;
    wait_clks(Q);
    i2c_start();
    byte_w(8'h76, a0);
    byte_w(8'h0F, a1);
    byte_w(8'h11, a2);
    byte_w(8'h22, a3);
    i2c_stop();
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_fail++; $display("FAIL wrap_acks: got %b required 0000", {a0, a1, a2, a3}); end
    n_cmp++; if (ws4_ptr.size() - k !== 2) begin n_fail++; $display("FAIL wrap_ws_count: got %0d required 2", ws4_ptr.size() - k); end
    if (ws4_ptr.size() - k == 2) begin
      n_cmp++; if ({ws4_ptr[k], ws4_dat[k]} !== 16'h0F11) begin n_fail++; $display("FAIL wrap_first: got %h/%h required 0F/11", ws4_ptr[k], ws4_dat[k]); end
      n_cmp++; if ({ws4_ptr[k+1], ws4_dat[k+1]} !== 16'h0022) begin n_fail++; $display("FAIL wrap_second: got %h/%h required 00/22", ws4_ptr[k+1], ws4_dat[k+1]); end
    end
    n_cmp++; if (ptr4 !== 4'h1) begin n_fail++; $display("FAIL wrap_ptr_end: got %h required 1", ptr4); end
    sel = 1'b0;
    wait_clks(Q);
  endtask

  task automatic test_glitch_hold();
    logic a0, a1, a2;
    logic [7:0] b;
    int w0, hold_n;
    b = 8'hC3;
    w0 = ws_cnt;
    i2c_start();
    byte_w(8'h76, a0);
    byte_w(8'h30, a1);
    // Bits 7..1 each carry a 2-clk SCL glitch while low and a 2-clk SDA
    // glitch while high.
    for (int i = 7; i >= 1; i--) begin
      sda_m = b[i];  wait_clks(5);
      scl_m = 1'b1;  wait_clks(2);
      scl_m = 1'b0;  wait_clks(Q - 7);
      scl_m = 1'b1;  wait_clks(5);
      sda_m = ~b[i]; wait_clks(2);
      sda_m = b[i];  wait_clks(Q - 7);
      scl_m = 1'b0;  wait_clks(Q);
    end
    sda_m = b[0]; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    scl_m = 1'b0;
    hold_n = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (sda_out0 === 1'b0 && hold_n == 0) hold_n = i;
    end
    wait_clks(Q - 15);
    bit_r(a2);
    i2c_stop();
    // 2 sync stages + FILT(3) filter samples + HOLD(2) clks
    n_cmp++; if (hold_n !== 7) begin n_fail++; $display("FAIL hold_delay: got %0d clks required 7", hold_n); end
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL gl_acks: got %b required 000", {a0, a1, a2}); end
    n_cmp++; if (ws_cnt - w0 !== 1) begin n_fail++; $display("FAIL gl_ws_count: got %0d required 1", ws_cnt - w0); end
    if (ws_cnt - w0 == 1) begin
      n_cmp++; if ({ws_ptr[w0], ws_dat[w0]} !== 16'h30C3) begin n_fail++; $display("FAIL gl_byte: got %h/%h required 30/C3", ws_ptr[w0], ws_dat[w0]); end
    end
  endtask

  task automatic test_abort();
    logic a0, a1, a2, b0, b1;
    int w0, p0;
    w0 = ws_cnt; p0 = ps_cnt;
    i2c_start();
    byte_w(8'h76, a0);
    byte_w(8'h40, a1);
    bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b0);
    i2c_stop();
    n_cmp++; if (ws_cnt - w0 !== 0) begin n_fail++; $display("FAIL ab_ws: got %0d required 0", ws_cnt - w0); end
    n_cmp++; if (ps_cnt - p0 !== 1) begin n_fail++; $display("FAIL ab_ps: got %0d required 1", ps_cnt - p0); end
    n_cmp++; if ({act0, sda_out0} !== 2'b01) begin n_fail++; $display("FAIL ab_act_sda: got %b required 01", {act0, sda_out0}); end
    // Read from 0x50 (data 0x90) and reset while the DUT drives a 0 bit.
    i2c_start();
    byte_w(8'h76, a0);
    byte_w(8'h50, a1);
    i2c_start();
    byte_w(8'h77, a2);
    bit_r(b0);
    bit_r(b1);
    n_cmp++; if ({a0, a1, a2, b0, b1, sda_out0} !== 6'b000100) begin n_fail++; $display("FAIL rr_pre: got %b required 000100", {a0, a1, a2, b0, b1, sda_out0}); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (sda_out0 !== 1'b1) begin n_fail++; $display("FAIL rr_sda_async: got %b required 1", sda_out0); end
    n_cmp++; if ({act0, ptr0} !== 9'h000) begin n_fail++; $display("FAIL rr_act_ptr: got %b/%h required 0/00", act0, ptr0); end
    wait_clks(3);
    rstn = 1'b1;
    wait_clks(5);
    i2c_stop();
    w0 = ws_cnt;
    i2c_start();
    byte_w(8'h76, a0);
    byte_w(8'h05, a1);
    byte_w(8'h77, a2);
    i2c_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL rr_next_acks: got %b required 000", {a0, a1, a2}); end
    n_cmp++; if (ws_cnt - w0 !== 1) begin n_fail++; $display("FAIL rr_next_ws: got %0d required 1", ws_cnt - w0); end
    if (ws_cnt - w0 == 1) begin
      n_cmp++; if ({ws_ptr[w0], ws_dat[w0]} !== 16'h0577) begin n_fail++; $display("FAIL rr_next_byte: got %h/%h required 05/77", ws_ptr[w0], ws_dat[w0]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nomatch();
    test_wrap();
    test_glitch_hold();
    test_abort();
    wait_clks(5);
    n_cmp++; if (width_err !== 0) begin n_fail++; $display("FAIL strobe_width: got %0d multi-clk strobes required 0", width_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
